fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into the PC on reset.
REQ-002 Parameter MEM_TIMEOUT, default 16, number of REQ cycles without imem_ack before a fetch error is raised.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  current PC from the program counter register.
REQ-006 pcnext  output  32  next PC value presented to the program counter register.
REQ-007 pc_en  output  1  PC write enable; the PC loads pcnext on the rising edge where pc_en=1.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  instruction memory read address.
REQ-010 imem_ack  input  1  memory read completed; imem_rdata valid this cycle.
REQ-011 imem_rdata  input  32  instruction word from memory.
REQ-012 instr  output  32  registered instruction to decode.
REQ-013 instr_valid  output  1  instr holds a valid, unconsumed instruction.
REQ-014 instr_ready  input  1  decode/execute consumes instr this cycle.
REQ-015 jump, jump_target  input  1, 32  unconditional redirect for the consumed instruction.
REQ-016 branch_taken, branch_target  input  1, 32  taken-branch redirect for the consumed instruction.
REQ-017 fetch_err  output  1  sticky error flag (timeout or misaligned target).

Function
REQ-018 FSM states: RST, REQ, HOLD, ERR; one-hot or binary encoding is free.
REQ-019 RST: imem_req=0, instr_valid=0, pc_en=1, pcnext=RESET_PC; unconditionally moves to REQ on the next cycle.
REQ-020 REQ: imem_req=1, imem_addr=pc, pc_en=0; address stays stable until ack.
REQ-021 REQ with imem_ack=1: instr<=imem_rdata, go to HOLD; instr_valid=1 from the next cycle (1-cycle latency after ack).
REQ-022 REQ: a timeout counter increments each cycle without ack and clears on entering REQ; reaching MEM_TIMEOUT goes to ERR.
REQ-023 HOLD: imem_req=0, instr_valid=1, instr stable; pc_en=0 while instr_ready=0.
REQ-024 HOLD with instr_ready=1: pc_en=1 for exactly that cycle, instr_valid=0 next cycle, next state REQ.
REQ-025 pcnext select on the consume cycle, priority jump > branch_taken > sequential: jump_target, else branch_target, else pc+4 (modulo 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-026 Redirect inputs are sampled only on a consume cycle; ignored in all other states/cycles.
REQ-027 Misaligned selected target (bits[1:0] != 0): pcnext uses target with bits[1:0] forced to 0, fetch_err set; fetching continues.
REQ-028 ERR: imem_req=0, instr_valid=0, pc_en=0, fetch_err=1; exit only via reset.
REQ-029 imem_ack outside REQ is ignored; instr is not modified.
REQ-030 pcnext outside RST and consume cycles equals pc+4 (don't-care for the PC since pc_en=0, but defined for verification).

Reset
REQ-031 reset=1 on any edge forces RST regardless of state, including mid-REQ or in ERR; an outstanding memory ack is discarded.
REQ-032 Reset values: state=RST, instr=0, instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0; pc_en=1, pcnext=RESET_PC while reset asserted.

Verification
REQ-033 Reset then ack in the first REQ cycle, rdata=32'h2002_0005 -> pc=0, imem_addr=0, instr=32'h2002_0005, instr_valid=1 one cycle after ack.
REQ-034 HOLD, instr_ready=1, no redirect, pc=32'h0000_0010 -> pc_en=1 one cycle, pcnext=32'h0000_0014, next imem_addr=32'h0000_0014.
REQ-035 Consume with jump=1, jump_target=32'h40, branch_taken=1, branch_target=32'h80 -> pcnext=32'h40 (jump wins), fetch_err=0.
REQ-036 Consume with branch_taken=1, branch_target=32'h0000_0102 -> pcnext=32'h0000_0100, fetch_err=1 and stays 1 while fetching continues.
REQ-037 imem_ack held 0 for MEM_TIMEOUT=16 cycles in REQ -> ERR, fetch_err=1, imem_req=0; reset -> RST, fetch_err=0, pcnext=RESET_PC.
REQ-038 instr_ready=0 for 5 cycles in HOLD, then reset mid-REQ of the next fetch with a late ack -> instr stable for all 5 cycles, pc_en=0 throughout; ack discarded and instr_valid=0 after reset.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch sequencer.
// Issues one read at the external PC, holds the returned word for decode,
// then advances or redirects the PC when the word is consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pcnext,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_err
);

  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [31:0]   instr_nxt;
  logic          err_nxt;
  logic [31:0]   pc_seq;
  logic [31:0]   tgt;

  assign pc_seq      = pc + 32'd4;
  assign instr_valid = (state == ST_HOLD);

  // State, captured instruction, timeout counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RST;
      instr     <= 32'd0;
      tcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      instr     <= instr_nxt;
      tcnt      <= tcnt_nxt;
      fetch_err <= err_nxt;
    end
  end

  // Next-state, PC select and memory request decode.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    instr_nxt = instr;
    err_nxt   = fetch_err;
    pc_en     = 1'b0;
    pcnext    = pc_seq;
    imem_req  = 1'b0;
    imem_addr = pc;
    tgt       = 32'd0;

    case (state)
      ST_RST: begin
        pc_en     = 1'b1;
        pcnext    = RESET_PC;
        tcnt_nxt  = '0;
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          tcnt_nxt  = '0;
          state_nxt = ST_HOLD;
        end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_ERR;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          pc_en = 1'b1;
          if (jump)              tgt = jump_target;
          else if (branch_taken) tgt = branch_target;
          // Misaligned redirects are truncated to a word and flagged.
          if (jump || branch_taken) begin
            pcnext = {tgt[31:2], 2'b00};
            if (tgt[1:0] != 2'b00) err_nxt = 1'b1;
          end
          tcnt_nxt  = '0;
          state_nxt = ST_REQ;
        end
      end
      default: begin
        err_nxt = 1'b1;
      end
    endcase

    // Reset forces the PC load independent of the current state.
    if (reset) begin
      pc_en    = 1'b1;
      pcnext   = RESET_PC;
      imem_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with an external PC register.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pcnext;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pcnext        (pcnext),
    .pc_en         (pc_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  // Program counter register outside the fetch unit.
  always @(posedge clk) begin
    if (pc_en) pc <= pcnext;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    pc            = 32'h1234_5670;
    reset         = 1'b1;
    imem_rdata    = 32'd0;
    jump_target   = 32'd0;
    branch_target = 32'd0;
    clr();

    // Reset state
    step(); step();
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_pcnext", pcnext, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);

    // RST state for one cycle after release
    reset = 1'b0; #1;
    chk("st_rst_pc_en", 32'(pc_en), 32'd1);
    chk("st_rst_req", 32'(imem_req), 32'd0);

    // First REQ; redirect outside consume is ignored
    step();
    imem_ack = 1'b1; imem_rdata = 32'h2002_0005;
    jump = 1'b1; jump_target = 32'h0000_0040; #1;
    chk("req0_req", 32'(imem_req), 32'd1);
    chk("req0_addr", imem_addr, 32'h0);
    chk("req0_pc_en", 32'(pc_en), 32'd0);
    chk("req0_pcnext", pcnext, 32'h4);
    step(); clr(); #1;
    chk("hold0_valid", 32'(instr_valid), 32'd1);
    chk("hold0_instr", instr, 32'h2002_0005);
    chk("hold0_req", 32'(imem_req), 32'd0);
    chk("hold0_pcnext", pcnext, 32'h4);

    // Consume: jump beats branch
    instr_ready = 1'b1; jump = 1'b1; jump_target = 32'h40;
    branch_taken = 1'b1; branch_target = 32'h80; #1;
    chk("jmp_pc_en", 32'(pc_en), 32'd1);
    chk("jmp_pcnext", pcnext, 32'h40);
    step(); clr(); #1;
    chk("jmp_valid", 32'(instr_valid), 32'd0);
    chk("jmp_addr", imem_addr, 32'h40);
    chk("jmp_err", 32'(fetch_err), 32'd0);

    // Aligned branch to 0x10
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
    step(); clr();
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h10; #1;
    chk("br_pcnext", pcnext, 32'h10);
    step(); clr();
    imem_ack = 1'b1; imem_rdata = 32'hBBBB_0002; #1;
    chk("br_addr", imem_addr, 32'h10);

    // Sequential consume at pc=0x10
    step(); clr(); instr_ready = 1'b1; #1;
    chk("seq_pc_en", 32'(pc_en), 32'd1);
    chk("seq_pcnext", pcnext, 32'h14);
    step(); clr(); #1;
    chk("seq_addr", imem_addr, 32'h14);
    chk("seq_pc_en_off", 32'(pc_en), 32'd0);

    // Stall in HOLD for 5 cycles with a stray ack
    imem_ack = 1'b1; imem_rdata = 32'hCCCC_0003;
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_instr", instr, 32'hCCCC_0003);
      chk("stall_pc_en", 32'(pc_en), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      step();
    end
    clr(); instr_ready = 1'b1; #1;
    chk("stall_consume", pcnext, 32'h18);
    step(); clr(); #1;
    chk("req18_addr", imem_addr, 32'h18);
    step();

    // Reset mid-REQ coincident with a late ack
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step(); #1;
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_pc_en", 32'(pc_en), 32'd1);
    chk("midrst_pcnext", pcnext, 32'h0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    clr(); reset = 1'b0;
    step(); #1;
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", 32'(imem_req), 32'd1);

    // Misaligned branch target
    imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
    step(); clr();
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0102; #1;
    chk("mis_pcnext", pcnext, 32'h100);
    chk("mis_err_before", 32'(fetch_err), 32'd0);
    step(); clr(); #1;
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_addr", imem_addr, 32'h100);
    imem_ack = 1'b1;
    step(); clr(); instr_ready = 1'b1; #1;
    chk("mis_seq", pcnext, 32'h104);
    chk("mis_err_sticky", 32'(fetch_err), 32'd1);
    step(); clr();

    // PC+4 wrap at the top of the address space
    imem_ack = 1'b1;
    step(); clr();
    instr_ready = 1'b1; jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step(); clr(); #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    step(); clr(); instr_ready = 1'b1; #1;
    chk("wrap_pcnext", pcnext, 32'h0);
    step(); clr(); #1;
    chk("wrap_addr0", imem_addr, 32'h0);

    // Timeout after 16 REQ cycles without ack
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); #1;
    chk("to_err0", 32'(fetch_err), 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_err", 32'(fetch_err), 32'd0);
    end
    step();
    chk("to_err_set", 32'(fetch_err), 32'd1);
    chk("to_req_off", 32'(imem_req), 32'd0);
    chk("to_valid", 32'(instr_valid), 32'd0);
    chk("to_pc_en", 32'(pc_en), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    step(); step(); clr(); #1;
    chk("err_stays", 32'(fetch_err), 32'd1);
    chk("err_valid", 32'(instr_valid), 32'd0);
    chk("err_instr", instr, 32'h0);

    // Reset leaves ERR
    reset = 1'b1; #1;
    chk("err_rst_pc_en", 32'(pc_en), 32'd1);
    chk("err_rst_pcnext", pcnext, 32'h0);
    step(); #1;
    chk("err_rst_clr", 32'(fetch_err), 32'd0);
    chk("err_rst_req", 32'(imem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
